// File: rtl/dmux_dispatch_4bit_pkg.sv
// Shared widths, destination encodings and entry layout for the 4-bit dispatch feeder.
package dmux_dispatch_4bit_pkg;

    localparam int unsigned NumChan = 4;
    localparam int unsigned DataW   = 4;
    localparam int unsigned SelW    = 2;

    // Destination order matches demux channels a/b/c/d for sel 0..3.
    typedef enum logic [SelW-1:0] {
        DestA = 2'd0,
        DestB = 2'd1,
        DestC = 2'd2,
        DestD = 2'd3
    } dest_e;

    typedef struct packed {
        dest_e            dest;
        logic [DataW-1:0] data;
    } entry_t;

    localparam int unsigned EntryW = $bits(entry_t);

    // One-hot channel offer for a given select.
    function automatic logic [NumChan-1:0] sel_onehot(input logic [SelW-1:0] sel);
        logic [NumChan-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/dmux_dispatch_4bit_fifo.sv
// Synchronous FIFO holding dispatch entries; head entry is read straight from storage.
module dispatch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    // Guard against push when full and pop when empty so count stays in 0..DEPTH.
    assign full_o  = (count_q == FullCnt);
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale contents are never presented because empty gates the head.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/dmux_dispatch_4bit.sv
// Dispatch feeder: buffers tagged nibbles and offers the head to one of four demux channels.
module dmux_dispatch_4bit
    import dmux_dispatch_4bit_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned STALL_MAX = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DataW-1:0]       in_data_i,
    input  logic [SelW-1:0]        in_dest_i,
    output logic [DataW-1:0]       out_data_o,
    output logic [SelW-1:0]        out_sel_o,
    output logic [NumChan-1:0]     out_valid_o,
    input  logic [NumChan-1:0]     out_ready_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   stall_err_o,
    input  logic                   clr_err_i
);

    localparam logic [7:0] StallMax = 8'(STALL_MAX);

    entry_t            wr_entry;
    entry_t            head_entry;
    logic [EntryW-1:0] head_raw;
    logic [SelW-1:0]   head_sel;
    logic              full, empty, push, pop;
    logic [7:0]        stall_cnt_q, stall_cnt_d;
    logic              stall_err_q, stall_err_d;

    assign wr_entry   = '{dest: dest_e'(in_dest_i), data: in_data_i};
    assign head_entry = entry_t'(head_raw);
    assign head_sel   = head_entry.dest;

    // in_ready depends only on occupancy, never on out_ready.
    assign in_ready_o = ~full;
    assign push       = in_valid_i & ~full;

    dispatch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EntryW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .head_o  (head_raw),
        .count_o (count_o),
        .full_o  (full),
        .empty_o (empty)
    );

    // Head presentation; zeros when empty. Only the addressed channel's ready can pop.
    always_comb begin
        out_sel_o   = '0;
        out_data_o  = '0;
        out_valid_o = '0;
        if (!empty) begin
            out_sel_o   = head_sel;
            out_data_o  = head_entry.data;
            out_valid_o = sel_onehot(head_sel);
        end
    end

    assign pop = ~empty & out_ready_i[out_sel_o];

    // Stall counter next state; set dominates clear so a still-blocked head keeps the flag.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (empty || pop) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != 8'hFF) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
        stall_err_d = stall_err_q;
        if (clr_err_i) stall_err_d = 1'b0;
        if (stall_cnt_d >= StallMax) stall_err_d = 1'b1;
    end

    // Stall state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign stall_err_o = stall_err_q;

endmodule

// File: tb/tb_dmux_dispatch_4bit.sv
// Self-checking bench for dmux_dispatch_4bit: scenario tasks plus a queue-based scoreboard.
module tb_dmux_dispatch_4bit;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [1:0] in_dest;
    logic [3:0] out_data;
    logic [1:0] out_sel;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [2:0] count;
    logic       stall_err;
    logic       clr_err;

    int total = 0;
    int bad   = 0;

    // Scoreboard: {dest,data} of accepted entries, oldest first.
    logic [5:0] sbq [$];
    bit         mon_en   = 1'b0;
    int         dut_pops = 0;

    dmux_dispatch_4bit #(
        .DEPTH     (DEPTH),
        .STALL_MAX (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_dest_i   (in_dest),
        .out_data_o  (out_data),
        .out_sel_o   (out_sel),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .count_o     (count),
        .stall_err_o (stall_err),
        .clr_err_i   (clr_err)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: checks head/occupancy at negedge, then applies the upcoming edge.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [5:0] front;
            logic [3:0] exp_valid;
            bit         do_pop;
            bit         do_push;
            int         sz;
            sz = sbq.size();
            total++;
            if (count !== 3'(sz)) begin
                bad++;
                $display("FAIL sb_count t=%0t got=%0d exp=%0d", $time, count, sz);
            end
            total++;
            if (in_ready !== (sz < DEPTH)) begin
                bad++;
                $display("FAIL sb_in_ready t=%0t got=%b exp=%b", $time, in_ready, (sz < DEPTH));
            end
            do_pop = 1'b0;
            if (sz > 0) begin
                front     = sbq[0];
                exp_valid = 4'b0001 << front[5:4];
                total++;
                if (out_valid !== exp_valid || out_sel !== front[5:4]
                    || out_data !== front[3:0]) begin
                    bad++;
                    $display("FAIL sb_head t=%0t got v=%b s=%0d d=%h exp v=%b s=%0d d=%h", $time,
                             out_valid, out_sel, out_data, exp_valid, front[5:4], front[3:0]);
                end
                do_pop = out_ready[front[5:4]];
            end else begin
                total++;
                if (out_valid !== 4'b0 || out_sel !== 2'd0 || out_data !== 4'h0) begin
                    bad++;
                    $display("FAIL sb_empty t=%0t got v=%b s=%0d d=%h exp zeros", $time,
                             out_valid, out_sel, out_data);
                end
            end
            if ((out_valid & out_ready) != 4'b0) dut_pops++;
            do_push = in_valid && (sz < DEPTH);
            if (do_pop)  void'(sbq.pop_front());
            if (do_push) sbq.push_back({in_dest, in_data});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_dest   = 2'd0;
        out_ready = 4'b0;
        clr_err   = 1'b0;
        #12;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 4'b0 || count !== 3'd0) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b v=%b cnt=%0d exp rdy=1 v=0 cnt=0",
                     in_ready, out_valid, count);
        end
        total++;
        if (stall_err !== 1'b0 || out_data !== 4'h0 || out_sel !== 2'd0) begin
            bad++;
            $display("FAIL reset_misc got err=%b d=%h s=%0d exp 0/0/0", stall_err, out_data, out_sel);
        end
        rst_n = 1'b1;
        step();
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        out_ready = 4'b0100;
        in_valid  = 1'b1;
        in_dest   = 2'd2;
        in_data   = 4'hA;
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 4'b0100 || out_sel !== 2'd2 || out_data !== 4'hA) begin
            bad++;
            $display("FAIL single_head got v=%b s=%0d d=%h exp v=0100 s=2 d=a",
                     out_valid, out_sel, out_data);
        end
        step();
        total++;
        if (count !== 3'd0 || out_valid !== 4'b0) begin
            bad++;
            $display("FAIL single_pop got cnt=%0d v=%b exp cnt=0 v=0", count, out_valid);
        end
    endtask

    task automatic test_fill();
        out_ready = 4'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_dest  = 2'(i);
            in_data  = 4'(i + 1);
            step();
        end
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0 || count !== 3'd4) begin
            bad++;
            $display("FAIL fill_full got rdy=%b cnt=%0d exp rdy=0 cnt=4", in_ready, count);
        end
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] ev;
            ev = 4'b0001 << i;
            total++;
            if (out_valid !== ev || out_data !== 4'(i + 1)) begin
                bad++;
                $display("FAIL fill_drain[%0d] got v=%b d=%h exp v=%b d=%h", i, out_valid,
                         out_data, ev, 4'(i + 1));
            end
            step();
        end
        total++;
        if (count !== 3'd0) begin
            bad++;
            $display("FAIL fill_empty got cnt=%0d exp 0", count);
        end
    endtask

    task automatic test_stall();
        out_ready = 4'b1101;
        in_valid  = 1'b1;
        in_dest   = 2'd1;
        in_data   = 4'h5;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            bit exp_err;
            step();
            exp_err = (k >= 15);
            total++;
            if (stall_err !== exp_err || count !== 3'd1 || out_valid !== 4'b0010) begin
                bad++;
                $display("FAIL stall_k%0d got err=%b cnt=%0d v=%b exp err=%b cnt=1 v=0010", k,
                         stall_err, count, out_valid, exp_err);
            end
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        total++;
        if (stall_err !== 1'b1) begin
            bad++;
            $display("FAIL stall_clr_blocked got err=%b exp 1", stall_err);
        end
        out_ready = 4'hF;
        step();
        total++;
        if (stall_err !== 1'b1 || count !== 3'd0) begin
            bad++;
            $display("FAIL stall_sticky got err=%b cnt=%0d exp err=1 cnt=0", stall_err, count);
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        total++;
        if (stall_err !== 1'b0) begin
            bad++;
            $display("FAIL stall_clr got err=%b exp 0", stall_err);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 4'b0;
        in_valid  = 1'b1;
        in_dest   = 2'd3;
        in_data   = 4'h6;
        step();
        in_dest = 2'd0;
        in_data = 4'h7;
        step();
        // count=2: simultaneous push and pop
        out_ready = 4'b1000;
        in_dest   = 2'd1;
        in_data   = 4'h8;
        step();
        in_valid = 1'b0;
        total++;
        if (count !== 3'd2 || out_sel !== 2'd0 || out_data !== 4'h7) begin
            bad++;
            $display("FAIL b2b_simul got cnt=%0d s=%0d d=%h exp cnt=2 s=0 d=7", count, out_sel,
                     out_data);
        end
        out_ready = 4'hF;
        step();
        total++;
        if (out_sel !== 2'd1 || out_data !== 4'h8) begin
            bad++;
            $display("FAIL b2b_order got s=%0d d=%h exp s=1 d=8", out_sel, out_data);
        end
        step();
        // Full with pop: offered push must not be taken this edge.
        out_ready = 4'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_dest  = 2'(3 - i);
            in_data  = 4'(8'hB + i);
            step();
        end
        out_ready = 4'hF;
        in_dest   = 2'd2;
        in_data   = 4'h9;
        step();
        in_valid = 1'b0;
        total++;
        if (count !== 3'd3 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_full_pop got cnt=%0d rdy=%b exp cnt=3 rdy=1", count, in_ready);
        end
        for (int i = 0; i < 3; i++) step();
        total++;
        if (count !== 3'd0 || sbq.size() != 0) begin
            bad++;
            $display("FAIL b2b_drain got cnt=%0d sb=%0d exp 0/0", count, sbq.size());
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        out_ready = 4'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_dest  = 2'(i);
            in_data  = 4'(i + 2);
            step();
        end
        in_valid = 1'b0;
        waited   = 0;
        while (stall_err !== 1'b1 && waited < 40) begin
            step();
            waited++;
        end
        total++;
        if (stall_err !== 1'b1 || count !== 3'd3) begin
            bad++;
            $display("FAIL rmid_setup got err=%b cnt=%0d exp err=1 cnt=3", stall_err, count);
        end
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        total++;
        if (out_valid !== 4'b0 || in_ready !== 1'b1 || count !== 3'd0 || stall_err !== 1'b0) begin
            bad++;
            $display("FAIL rmid_async got v=%b rdy=%b cnt=%0d err=%b exp 0/1/0/0", out_valid,
                     in_ready, count, stall_err);
        end
        sbq.delete();
        step();
        #2;
        rst_n = 1'b1;
        step();
        mon_en    = 1'b1;
        out_ready = 4'b0001;
        in_valid  = 1'b1;
        in_dest   = 2'd0;
        in_data   = 4'hC;
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 4'b0001 || out_data !== 4'hC || count !== 3'd1) begin
            bad++;
            $display("FAIL rmid_after got v=%b d=%h cnt=%0d exp v=0001 d=c cnt=1", out_valid,
                     out_data, count);
        end
        step();
    endtask

    task automatic test_wrap();
        int pops0;
        pops0     = dut_pops;
        out_ready = 4'hF;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_dest  = 2'($urandom_range(0, 3));
            in_data  = 4'($urandom_range(0, 15));
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        total++;
        if (dut_pops - pops0 != 10 || count !== 3'd0 || sbq.size() != 0) begin
            bad++;
            $display("FAIL wrap_xfers got pops=%0d cnt=%0d sb=%0d exp 10/0/0", dut_pops - pops0,
                     count, sbq.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
